// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM states and constants for the stalling data memory.
package dmem_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [31:0] MAILBOX_ADDR = 32'h64;
   localparam int CNT_W = 3;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: word RAM with synchronous write and asynchronous read; never reset.
module dmem_array #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [31:0] r_mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) r_mem[addr] <= wdata;
   end
   assign rdata = r_mem[addr];
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: data memory that stalls the pipeline LATENCY cycles per access, then responds.
// Optional mailbox at byte 0x64 (Done/MailData) enabled by defining DMEM_MAILBOX_EN.
module data_mem_resp
   import dmem_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [31:0] DataAdr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AlignErr,
   output logic        Done,
   output logic [31:0] MailData
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [31:0]      r_rdata, w_mem_rdata;
   logic [AW-1:0]    w_idx;
   logic             w_req, w_ok, w_accept, w_to_resp, w_we;
   assign w_req     = MemWrite | MemRead;
   assign w_ok      = DataAdr[1:0] == 2'b00;
   assign w_accept  = !reset && r_state == IDLE && w_req && w_ok;
   assign w_to_resp = (w_accept && LATENCY == 1) || (r_state == WAIT && r_cnt <= CNT_W'(1));
   // The write lands on the edge leaving RESP, so a same-cycle read sees the old word.
   assign w_we      = !reset && r_state == RESP && MemWrite;
   assign w_idx     = AW'(DataAdr[31:2] % DEPTH);
   assign Stall     = w_accept || (!reset && r_state == WAIT);
   assign AlignErr  = !reset && r_state == IDLE && w_req && !w_ok;
   assign ReadData  = r_rdata;
   dmem_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
      .clk   (clk),
      .we    (w_we),
      .addr  (w_idx),
      .wdata (WriteData),
      .rdata (w_mem_rdata)
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_to_resp ? RESP : w_accept ? WAIT : r_state == RESP ? IDLE : r_state;
         r_cnt   <= w_accept ? CNT_W'(LATENCY - 1) : r_state == WAIT ? r_cnt - CNT_W'(1) : r_cnt;
         if (w_to_resp && MemRead) r_rdata <= w_mem_rdata;
      end
   end
`ifdef DMEM_MAILBOX_EN
   logic        r_done;
   logic [31:0] r_mail;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_done <= 1'b0;
         r_mail <= '0;
      end else if (w_we && DataAdr == MAILBOX_ADDR) begin
         r_done <= 1'b1;
         r_mail <= WriteData;
      end
   end
   assign Done     = r_done;
   assign MailData = r_mail;
`else
   assign Done     = 1'b0;
   assign MailData = '0;
`endif
endmodule
